// File: rtl/ahb_dma_pkg.sv
// Shared AHB-Lite encodings and the DMA state encoding.
package ahb_dma_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_t;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RADDR = 3'd1,
        RDATA = 3'd2,
        WADDR = 3'd3,
        WDATA = 3'd4
    } state_t;

endpackage

// File: rtl/ahb_dma_if.sv
// AHB-Lite master bus bundle used by the DMA engine.
interface ahb_dma_if;
    logic [1:0]  M_HTRANS;
    logic        M_HWRITE;
    logic        M_HMASTLOCK;
    logic [2:0]  M_HSIZE;
    logic [2:0]  M_HBURST;
    logic [3:0]  M_HPROT;
    logic [31:0] M_HADDR;
    logic [31:0] M_HWDATA;
    logic        M_HREADY;
    logic [31:0] M_HRDATA;
    logic        M_HRESP;

    modport master (
        output M_HTRANS, M_HWRITE, M_HMASTLOCK, M_HSIZE, M_HBURST, M_HPROT,
               M_HADDR, M_HWDATA,
        input  M_HREADY, M_HRDATA, M_HRESP
    );

    modport slave (
        input  M_HTRANS, M_HWRITE, M_HMASTLOCK, M_HSIZE, M_HBURST, M_HPROT,
               M_HADDR, M_HWDATA,
        output M_HREADY, M_HRDATA, M_HRESP
    );
endinterface

// File: rtl/ahb_dma.sv
// Single-channel word-copy DMA: one read then one write per word over AHB-Lite,
// with abort honoured at word boundaries and a sticky error flag.
module ahb_dma
    import ahb_dma_pkg::*;
#(
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        START,
    input  logic [31:0] SRC_ADDR,
    input  logic [31:0] DST_ADDR,
    input  logic [15:0] COUNT,
    input  logic        ABORT,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERROR,
    output logic [15:0] REMAIN,
    ahb_dma_if.master   m
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_src;
    logic [31:0] r_dst;
    logic [31:0] r_buf;
    logic [15:0] r_remain;
    logic        r_done;
    logic        r_error;
    logic        r_abort_pend;

    logic        w_start;
    logic        w_zero;
    logic        w_rd_cap;
    logic        w_word_done;
    logic        w_err;
    logic        w_end;

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_zero      = 1'b0;
        w_rd_cap    = 1'b0;
        w_word_done = 1'b0;
        w_err       = 1'b0;
        w_end       = 1'b0;
        case (r_state)
            IDLE: begin
                if (START) begin
                    if (COUNT != 16'd0) begin
                        w_start     = 1'b1;
                        w_state_nxt = RADDR;
                    end else begin
                        w_zero = 1'b1;
                        w_end  = 1'b1;
                    end
                end
            end
            RADDR: if (m.M_HREADY) w_state_nxt = RDATA;
            RDATA: begin
                if (m.M_HREADY) begin
                    if (m.M_HRESP) begin
                        w_err       = 1'b1;
                        w_end       = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_rd_cap    = 1'b1;
                        w_state_nxt = WADDR;
                    end
                end
            end
            WADDR: if (m.M_HREADY) w_state_nxt = WDATA;
            WDATA: begin
                if (m.M_HREADY) begin
                    // An error response wins over any pending abort.
                    if (m.M_HRESP) begin
                        w_err       = 1'b1;
                        w_end       = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_word_done = 1'b1;
                        if (r_remain == 16'd1 || r_abort_pend) begin
                            w_end       = 1'b1;
                            w_state_nxt = IDLE;
                        end else begin
                            w_state_nxt = RADDR;
                        end
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            r_src        <= '0;
            r_dst        <= '0;
            r_buf        <= '0;
            r_remain     <= '0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_abort_pend <= 1'b0;
        end else begin
            r_done <= w_end;
            if (w_start) begin
                r_src    <= SRC_ADDR & 32'hFFFF_FFFC;
                r_dst    <= DST_ADDR & 32'hFFFF_FFFC;
                r_remain <= COUNT;
            end
            if (w_start || w_zero) r_error <= 1'b0;
            else if (w_err)        r_error <= 1'b1;
            if (w_rd_cap) r_buf <= m.M_HRDATA;
            if (w_word_done) begin
                r_src    <= r_src + 32'd4;
                r_dst    <= r_dst + 32'd4;
                r_remain <= r_remain - 16'd1;
            end
            if (w_end)                          r_abort_pend <= 1'b0;
            else if (ABORT && r_state != IDLE)  r_abort_pend <= 1'b1;
        end
    end

    // Bus outputs derive only from state and pointers, which hold while stalled.
    assign m.M_HTRANS    = (r_state == RADDR || r_state == WADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign m.M_HWRITE    = (r_state == WADDR);
    assign m.M_HADDR     = (r_state == WADDR) ? r_dst : r_src;
    assign m.M_HWDATA    = r_buf;
    assign m.M_HMASTLOCK = 1'b0;
    assign m.M_HSIZE     = HSIZE_WORD;
    assign m.M_HBURST    = HBURST_SINGLE;
    assign m.M_HPROT     = HPROT_VAL;

    assign BUSY   = (r_state != IDLE);
    assign DONE   = r_done;
    assign ERROR  = r_error;
    assign REMAIN = r_remain;

endmodule

// File: tb/tb_ahb_dma.sv
// Directed bench for ahb_dma with a RAM slave model (optional wait states,
// two-cycle error injection and a forced stall).
module tb_ahb_dma;
    import ahb_dma_pkg::*;

    logic        CLK = 1'b0;
    logic        RES = 1'b1;
    logic        START = 1'b0;
    logic [31:0] SRC_ADDR = '0;
    logic [31:0] DST_ADDR = '0;
    logic [15:0] COUNT = '0;
    logic        ABORT = 1'b0;
    logic        BUSY, DONE, ERROR;
    logic [15:0] REMAIN;

    int n_checks = 0;
    int n_fail   = 0;

    ahb_dma_if bus ();

    ahb_dma #(.HPROT_VAL(4'b0011)) dut (
        .CLK(CLK), .RES(RES), .START(START), .SRC_ADDR(SRC_ADDR),
        .DST_ADDR(DST_ADDR), .COUNT(COUNT), .ABORT(ABORT), .BUSY(BUSY),
        .DONE(DONE), .ERROR(ERROR), .REMAIN(REMAIN), .m(bus)
    );

    always #5 CLK = ~CLK;

    // RAM slave: 1024 words at 0x0000
    logic [31:0] mem [0:1023];
    logic        force_stall = 1'b0;
    logic        wait_en = 1'b0;
    logic        err_en = 1'b0;
    logic [31:0] err_addr = '0;
    logic        fill_go = 1'b0;
    logic        dp_act, dp_wr, dp_err, err_stg;
    logic [1:0]  dp_wait;
    logic [31:0] dp_addr;

    assign bus.M_HREADY = !force_stall && !(dp_act && (dp_err ? !err_stg : (dp_wait != 2'd0)));
    assign bus.M_HRESP  = dp_act && dp_err;
    assign bus.M_HRDATA = mem[dp_addr[11:2]];

    always @(posedge CLK or posedge RES) begin
        if (RES) begin
            dp_act  <= 1'b0;
            dp_wr   <= 1'b0;
            dp_err  <= 1'b0;
            err_stg <= 1'b0;
            dp_wait <= 2'd0;
            dp_addr <= '0;
        end else begin
            if (fill_go) begin
                for (int unsigned i = 0; i < 1024; i++)
                    mem[i] = (i >= 64 && i < 72) ? (i - 63) * 32'h1111_1111 : 32'hDEAD_BEEF;
            end
            if (dp_act) begin
                if (dp_err) begin
                    if (!err_stg) err_stg <= 1'b1;
                    else          dp_act  <= 1'b0;
                end else if (dp_wait != 2'd0) begin
                    dp_wait <= dp_wait - 2'd1;
                end else begin
                    if (dp_wr) mem[dp_addr[11:2]] = bus.M_HWDATA;
                    dp_act <= 1'b0;
                end
            end
            if (bus.M_HREADY && bus.M_HTRANS == HTRANS_NONSEQ) begin
                dp_act  <= 1'b1;
                dp_wr   <= bus.M_HWRITE;
                dp_addr <= bus.M_HADDR;
                dp_wait <= wait_en ? bus.M_HADDR[3:2] : 2'd0;
                dp_err  <= err_en && bus.M_HWRITE && (bus.M_HADDR == err_addr);
                err_stg <= 1'b0;
            end
        end
    end

    task automatic fill_mem();
        @(negedge CLK);
        fill_go = 1'b1;
        @(negedge CLK);
        fill_go = 1'b0;
    endtask

    task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] c);
        @(negedge CLK);
        START = 1'b1; SRC_ADDR = s; DST_ADDR = d; COUNT = c;
        @(negedge CLK);
        START = 1'b0;
    endtask

    // Runs until DONE (bounded); measures cycles, wait cycles, stall changes, accepted writes.
    task automatic run_until_done(input logic [31:0] abort_at, output int cyc, output int waits,
                                  output int bad, output int wrs);
        logic        p_rdy, p_wr;
        logic [31:0] p_addr;
        logic [1:0]  p_tr;
        cyc = 0; waits = 0; bad = 0; wrs = 0;
        while (DONE !== 1'b1 && cyc < 500) begin
            p_rdy = bus.M_HREADY; p_wr = bus.M_HWRITE; p_addr = bus.M_HADDR; p_tr = bus.M_HTRANS;
            if (bus.M_HTRANS == HTRANS_NONSEQ && bus.M_HWRITE && bus.M_HREADY) wrs++;
            if (BUSY && !bus.M_HREADY) waits++;
            ABORT = (bus.M_HTRANS == HTRANS_NONSEQ) && !bus.M_HWRITE && (bus.M_HADDR == abort_at);
            @(negedge CLK);
            cyc++;
            if (!p_rdy && (bus.M_HADDR !== p_addr || bus.M_HWRITE !== p_wr || bus.M_HTRANS !== p_tr))
                bad++;
        end
        ABORT = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        n_checks++; if ({BUSY, DONE, ERROR} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {BUSY, DONE, ERROR}); end
        n_checks++; if (REMAIN !== 16'd0) begin n_fail++; $display("FAIL reset_remain: got %h expected 0000", REMAIN); end
        n_checks++; if (bus.M_HTRANS !== 2'b00 || bus.M_HWRITE !== 1'b0) begin n_fail++; $display("FAIL reset_trans: got %b/%b expected 00/0", bus.M_HTRANS, bus.M_HWRITE); end
        n_checks++; if (bus.M_HADDR !== 32'h0 || bus.M_HWDATA !== 32'h0) begin n_fail++; $display("FAIL reset_bus: got %h/%h expected 0/0", bus.M_HADDR, bus.M_HWDATA); end
        n_checks++; if ({bus.M_HSIZE, bus.M_HBURST, bus.M_HMASTLOCK, bus.M_HPROT} !== {3'b010, 3'b000, 1'b0, 4'b0011}) begin n_fail++; $display("FAIL const_ctrl: got %b expected 01000000011", {bus.M_HSIZE, bus.M_HBURST, bus.M_HMASTLOCK, bus.M_HPROT}); end
        RES = 1'b0;
    endtask

    task automatic test_basic();
        int cyc, waits, bad, wrs;
        fill_mem();
        do_start(32'h100, 32'h200, 16'd4);
        n_checks++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", BUSY); end
        run_until_done(32'hFFFF_FFFF, cyc, waits, bad, wrs);
        n_checks++; if (cyc != 16) begin n_fail++; $display("FAIL basic_cycles: got %0d expected 16", cyc); end
        n_checks++; if (wrs != 4) begin n_fail++; $display("FAIL basic_writes: got %0d expected 4", wrs); end
        for (int unsigned i = 0; i < 4; i++) begin
            n_checks++; if (mem[128 + i] !== (i + 1) * 32'h1111_1111) begin n_fail++; $display("FAIL basic_data[%0d]: got %h expected %h", i, mem[128 + i], (i + 1) * 32'h1111_1111); end
        end
        n_checks++; if (REMAIN !== 16'd0 || ERROR !== 1'b0) begin n_fail++; $display("FAIL basic_end: got remain %h error %b expected 0000 0", REMAIN, ERROR); end
        @(negedge CLK);
        n_checks++; if (DONE !== 1'b0 || BUSY !== 1'b0) begin n_fail++; $display("FAIL basic_pulse: got done %b busy %b expected 0 0", DONE, BUSY); end
    endtask

    task automatic test_wait_states();
        int cyc, waits, bad, wrs;
        fill_mem();
        wait_en = 1'b1;
        do_start(32'h100, 32'h200, 16'd4);
        run_until_done(32'hFFFF_FFFF, cyc, waits, bad, wrs);
        wait_en = 1'b0;
        n_checks++; if (cyc != 28) begin n_fail++; $display("FAIL wait_cycles: got %0d expected 28", cyc); end
        n_checks++; if (waits != 12) begin n_fail++; $display("FAIL wait_count: got %0d expected 12", waits); end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL wait_stable: got %0d changes expected 0", bad); end
        for (int unsigned i = 0; i < 4; i++) begin
            n_checks++; if (mem[128 + i] !== (i + 1) * 32'h1111_1111) begin n_fail++; $display("FAIL wait_data[%0d]: got %h expected %h", i, mem[128 + i], (i + 1) * 32'h1111_1111); end
        end
    endtask

    task automatic test_zero_count();
        int ns;
        ns = 0;
        do_start(32'h100, 32'h200, 16'd0);
        n_checks++; if (DONE !== 1'b1 || BUSY !== 1'b0) begin n_fail++; $display("FAIL zero_done: got done %b busy %b expected 1 0", DONE, BUSY); end
        for (int k = 0; k < 4; k++) begin
            if (bus.M_HTRANS == HTRANS_NONSEQ || BUSY) ns++;
            @(negedge CLK);
        end
        n_checks++; if (ns != 0) begin n_fail++; $display("FAIL zero_idle: got %0d active cycles expected 0", ns); end
        n_checks++; if (DONE !== 1'b0) begin n_fail++; $display("FAIL zero_pulse: got %b expected 0", DONE); end
    endtask

    task automatic test_abort();
        int cyc, waits, bad, wrs;
        fill_mem();
        do_start(32'h100, 32'h300, 16'd8);
        run_until_done(32'h108, cyc, waits, bad, wrs);
        n_checks++; if (cyc != 12) begin n_fail++; $display("FAIL abort_cycles: got %0d expected 12", cyc); end
        n_checks++; if (wrs != 3) begin n_fail++; $display("FAIL abort_writes: got %0d expected 3", wrs); end
        n_checks++; if (REMAIN !== 16'd5 || ERROR !== 1'b0) begin n_fail++; $display("FAIL abort_remain: got %h error %b expected 0005 0", REMAIN, ERROR); end
        n_checks++; if (mem[194] !== 32'h3333_3333 || mem[195] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL abort_data: got %h %h expected 33333333 deadbeef", mem[194], mem[195]); end
        @(negedge CLK);
        n_checks++; if (BUSY !== 1'b0 || DONE !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got busy %b done %b expected 0 0", BUSY, DONE); end
    endtask

    task automatic test_error();
        int cyc, waits, bad, wrs, ns;
        fill_mem();
        err_en = 1'b1; err_addr = 32'h404;
        do_start(32'h100, 32'h400, 16'd4);
        run_until_done(32'hFFFF_FFFF, cyc, waits, bad, wrs);
        err_en = 1'b0;
        n_checks++; if (cyc != 9) begin n_fail++; $display("FAIL err_cycles: got %0d expected 9", cyc); end
        n_checks++; if (ERROR !== 1'b1 || REMAIN !== 16'd3) begin n_fail++; $display("FAIL err_flag: got error %b remain %h expected 1 0003", ERROR, REMAIN); end
        n_checks++; if (mem[256] !== 32'h1111_1111 || mem[257] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL err_data: got %h %h expected 11111111 deadbeef", mem[256], mem[257]); end
        ns = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            if (bus.M_HTRANS == HTRANS_NONSEQ) ns++;
        end
        n_checks++; if (ns != 0 || ERROR !== 1'b1) begin n_fail++; $display("FAIL err_quiet: got %0d nonseq error %b expected 0 1", ns, ERROR); end
        do_start(32'h100, 32'h600, 16'd1);
        n_checks++; if (ERROR !== 1'b0 || BUSY !== 1'b1) begin n_fail++; $display("FAIL err_clear: got error %b busy %b expected 0 1", ERROR, BUSY); end
        run_until_done(32'hFFFF_FFFF, cyc, waits, bad, wrs);
        n_checks++; if (mem[384] !== 32'h1111_1111) begin n_fail++; $display("FAIL err_recover: got %h expected 11111111", mem[384]); end
    endtask

    task automatic test_align();
        int cyc, waits, bad, wrs;
        fill_mem();
        do_start(32'h103, 32'h702, 16'd1);
        run_until_done(32'hFFFF_FFFF, cyc, waits, bad, wrs);
        n_checks++; if (mem[448] !== 32'h1111_1111 || mem[449] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL align_data: got %h %h expected 11111111 deadbeef", mem[448], mem[449]); end
    endtask

    task automatic test_reset_stall();
        int cyc, waits, bad, wrs, k;
        fill_mem();
        do_start(32'h100, 32'h500, 16'd2);
        k = 0;
        while (!(bus.M_HTRANS == HTRANS_NONSEQ && bus.M_HWRITE) && k < 50) begin
            @(negedge CLK); k++;
        end
        n_checks++; if (k >= 50) begin n_fail++; $display("FAIL rst_reach_waddr: got timeout expected WADDR"); end
        force_stall = 1'b1;
        @(negedge CLK);
        n_checks++; if (bus.M_HTRANS !== 2'b10 || bus.M_HWRITE !== 1'b1 || bus.M_HADDR !== 32'h500) begin n_fail++; $display("FAIL rst_stall_hold: got %b %b %h expected 10 1 00000500", bus.M_HTRANS, bus.M_HWRITE, bus.M_HADDR); end
        #2 RES = 1'b1;
        #1;
        n_checks++; if ({BUSY, DONE, ERROR, REMAIN} !== 19'd0) begin n_fail++; $display("FAIL rst_async_flags: got %b %b %b %h expected 0 0 0 0000", BUSY, DONE, ERROR, REMAIN); end
        n_checks++; if (bus.M_HTRANS !== 2'b00 || bus.M_HWRITE !== 1'b0 || bus.M_HADDR !== 32'h0 || bus.M_HWDATA !== 32'h0) begin n_fail++; $display("FAIL rst_async_bus: got %b %b %h %h expected 00 0 0 0", bus.M_HTRANS, bus.M_HWRITE, bus.M_HADDR, bus.M_HWDATA); end
        @(negedge CLK);
        RES = 1'b0; force_stall = 1'b0;
        n_checks++; if (mem[320] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rst_no_write: got %h expected deadbeef", mem[320]); end
        do_start(32'h100, 32'h500, 16'd1);
        run_until_done(32'hFFFF_FFFF, cyc, waits, bad, wrs);
        n_checks++; if (cyc != 4) begin n_fail++; $display("FAIL rst_restart_cycles: got %0d expected 4", cyc); end
        n_checks++; if (mem[320] !== 32'h1111_1111 || mem[321] !== 32'hDEAD_BEEF || REMAIN !== 16'd0) begin n_fail++; $display("FAIL rst_restart_data: got %h %h remain %h expected 11111111 deadbeef 0000", mem[320], mem[321], REMAIN); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait_states();
        test_zero_count();
        test_abort();
        test_error();
        test_align();
        test_reset_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
